clock_field_counter: RTL

//  Parametrised modulo counter for one clock field (seconds, minutes or hours) with a shadow alarm register.

---
 rtl/clock_field_counter_if.sv | 29 ++
 rtl/clock_field_counter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clock_field_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_field_counter_if
// Description : Control/status bundle of one clock field counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_field_counter_if #(
    parameter int WIDTH = 8
) ();
    logic             tick_in;
    logic [1:0]       mode;
    logic             adj_up;
    logic             adj_dn;
    logic [WIDTH-1:0] count_out;
    logic [WIDTH-1:0] alarm_out;
    logic             carry_out;
    logic             match_out;

    modport master (
        output tick_in, mode, adj_up, adj_dn,
        input  count_out, alarm_out, carry_out, match_out
    );

    modport slave (
        input  tick_in, mode, adj_up, adj_dn,
        output count_out, alarm_out, carry_out, match_out
    );
endinterface
`default_nettype wire

// File: rtl/clock_field_counter.sv
`default_nettype none
// ============================================================================
// Module      : clock_field_counter
// Description : Modulo counter for one time-of-day field with adjust
//               buttons (edge + hold-to-repeat) and a shadow alarm register.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_field_counter #(
    parameter int MODULUS     = 60,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 500,
    parameter int REPEAT_CYC  = 100
) (
    input  wire logic             clk,
    input  wire logic             reset,
    clock_field_counter_if.slave  bus
);

    localparam logic [1:0] c_mode_run   = 2'b00;
    localparam logic [1:0] c_mode_set_t = 2'b01;
    localparam logic [1:0] c_mode_set_a = 2'b10;

    localparam int c_hold_max = (HOLD_CYCLES > REPEAT_CYC) ? HOLD_CYCLES : REPEAT_CYC;
    localparam int c_cw       = $clog2(c_hold_max + 1);

    localparam logic [c_cw-1:0]  c_hold = c_cw'(HOLD_CYCLES);
    localparam logic [c_cw-1:0]  c_rep  = c_cw'(REPEAT_CYC);
    localparam logic [c_cw-1:0]  c_one  = c_cw'(1);
    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);

    // Out-of-range values collapse to 0 on any step.
    function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] v);
        return (v >= c_max) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] f_dec(input logic [WIDTH-1:0] v);
        if (v > c_max)
            return '0;
        else if (v == '0)
            return c_max;
        else
            return v - 1'b1;
    endfunction

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_alarm;
    logic             r_match;
    logic [1:0]       r_mode_prev;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_alarm_nxt;
    logic [1:0]       w_lvl;
    logic [1:0]       w_step;
    logic             w_both;
    logic             w_mode_chg;

    assign w_lvl      = {bus.adj_dn, bus.adj_up};
    assign w_both     = bus.adj_up & bus.adj_dn;
    assign w_mode_chg = (bus.mode != r_mode_prev);

    // Per button: edge flop, armed flag (set by a real press), hold/repeat timer.
    // r_prev resets high so a button held through reset needs a fresh press.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            r_prev;
        logic            r_armed;
        logic            r_rep;
        logic [c_cw-1:0] r_cnt;
        logic            w_rise;
        logic            w_fire;
        logic            w_block;

        assign w_block = w_both | w_mode_chg;
        assign w_rise  = w_lvl[b] & ~r_prev;
        assign w_fire  = r_armed & w_lvl[b] & (r_rep ? (r_cnt == c_rep) : (r_cnt == c_hold));
        assign w_step[b] = ~w_block & (w_rise | w_fire);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_prev  <= 1'b1;
                r_armed <= 1'b0;
                r_rep   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_prev <= w_lvl[b];
                if (w_block || !w_lvl[b]) begin
                    r_armed <= 1'b0;
                    r_rep   <= 1'b0;
                    r_cnt   <= '0;
                end else if (w_rise) begin
                    r_armed <= 1'b1;
                    r_rep   <= 1'b0;
                    r_cnt   <= c_one;
                end else if (r_armed) begin
                    if (w_fire) begin
                        r_rep <= 1'b1;
                        r_cnt <= c_one;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_alarm_nxt = r_alarm;
        case (bus.mode)
            c_mode_run: begin
                if (bus.tick_in)
                    w_count_nxt = f_inc(r_count);
            end
            c_mode_set_t: begin
                if (w_step[0])
                    w_count_nxt = f_inc(r_count);
                else if (w_step[1])
                    w_count_nxt = f_dec(r_count);
            end
            c_mode_set_a: begin
                if (bus.tick_in)
                    w_count_nxt = f_inc(r_count);
                if (w_step[0])
                    w_alarm_nxt = f_inc(r_alarm);
                else if (w_step[1])
                    w_alarm_nxt = f_dec(r_alarm);
            end
            default: begin
                w_count_nxt = r_count;
                w_alarm_nxt = r_alarm;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_alarm     <= '0;
            r_match     <= 1'b1;
            r_mode_prev <= bus.mode;
        end else begin
            r_count     <= w_count_nxt;
            r_alarm     <= w_alarm_nxt;
            r_match     <= (r_count == r_alarm);
            r_mode_prev <= bus.mode;
        end
    end

    // Lookahead carry: asserted in the same cycle as the wrap it announces.
    assign bus.carry_out = ~reset & bus.tick_in & (r_count == c_max) &
                           ((bus.mode == c_mode_run) | (bus.mode == c_mode_set_a));
    assign bus.count_out = r_count;
    assign bus.alarm_out = r_alarm;
    assign bus.match_out = r_match;

endmodule
`default_nettype wire
